// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C receive-side target.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  localparam logic [I2C_ADDR_W-1:0] I2C_GENERAL_CALL_ADDR = 7'h00;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RW,
    ACK_A,
    DATA,
    ACK_D,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_slave_rx_if.sv
// Bus-side and receive-side signals of the I2C target, grouped for port connection.
interface i2c_slave_rx_if;
  import i2c_pkg::*;

  logic                  scl;
  logic                  sda;
  logic                  sda_oe;
  logic [I2C_DATA_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_rw;
  logic                  addr_match;
  logic                  busy;

  modport slave (
    input  scl,
    input  sda,
    output sda_oe,
    output rx_data,
    output rx_valid,
    output rx_rw,
    output addr_match,
    output busy
  );

  modport master (
    output scl,
    output sda,
    input  sda_oe,
    input  rx_data,
    input  rx_valid,
    input  rx_rw,
    input  addr_match,
    input  busy
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizer chain, delay flop and edge pulses for one asynchronous bus line.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  // No reset: the chain keeps tracking the live bus so a reset never fakes an edge.
  always_ff @(posedge clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
    r_dly  <= r_sync[SYNC_STAGES-1];
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C receive-side target: START/STOP detect, address match with ACK, byte delivery.
// Optional: define I2C_SLAVE_GENERAL_CALL_EN to also accept the general-call address on writes.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h27,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset,
  i2c_slave_rx_if.slave bus
);

  logic w_scl;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_sda;
  logic w_sda_rise;
  logic w_sda_fall;
  logic w_start;
  logic w_stop;
  logic w_own_hit;
  logic w_gc_hit;
  logic w_addr_hit;

  i2c_state_e            r_state;
  logic [2:0]            r_bit_cnt;
  logic                  r_bit_done;
  logic [I2C_DATA_W-1:0] r_shift;
  logic                  r_sda_oe;
  logic [I2C_DATA_W-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_rx_rw;
  logic                  r_addr_match;
  logic                  r_busy;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_scl_sync (
    .clk     (clk),
    .i_line  (bus.scl),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sda_sync (
    .clk     (clk),
    .i_line  (bus.sda),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  // Address sits in the low 7 shift bits once the R/W bit has been latched.
  assign w_own_hit = (r_shift[I2C_ADDR_W-1:0] == SLAVE_ADDR);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
  assign w_gc_hit = (r_shift[I2C_ADDR_W-1:0] == I2C_GENERAL_CALL_ADDR) & ~r_rx_rw;
`else
  assign w_gc_hit = 1'b0;
`endif
  assign w_addr_hit = w_own_hit | w_gc_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 3'd0;
      r_bit_done   <= 1'b0;
      r_shift      <= '0;
      r_sda_oe     <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_rw      <= 1'b0;
      r_addr_match <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_start) begin
        r_busy       <= 1'b1;
        r_sda_oe     <= 1'b0;
        r_addr_match <= 1'b0;
        r_bit_done   <= 1'b0;
        r_bit_cnt    <= 3'd6;
        r_state      <= ADDR;
      end else if (w_stop) begin
        r_busy       <= 1'b0;
        r_sda_oe     <= 1'b0;
        r_addr_match <= 1'b0;
        r_bit_done   <= 1'b0;
        r_state      <= IDLE;
      end else begin
        unique case (r_state)
          IDLE, IGNORE: begin
            r_sda_oe <= 1'b0;
          end
          ADDR: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[I2C_DATA_W-2:0], w_sda};
              if (r_bit_cnt == 3'd0) begin
                r_state <= RW;
              end else begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
              end
            end
          end
          RW: begin
            // The falling edge of address bit 0 also arrives here; wait for the R/W sample.
            if (w_scl_rise) begin
              r_rx_rw    <= w_sda;
              r_bit_done <= 1'b1;
            end else if (w_scl_fall && r_bit_done) begin
              r_bit_done <= 1'b0;
              if (w_addr_hit) begin
                r_sda_oe     <= 1'b1;
                r_addr_match <= 1'b1;
                r_state      <= ACK_A;
              end else begin
                r_state <= IGNORE;
              end
            end
          end
          ACK_A, ACK_D: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 3'd7;
              r_state   <= DATA;
            end
          end
          DATA: begin
            if (w_scl_rise && !r_bit_done) begin
              r_shift <= {r_shift[I2C_DATA_W-2:0], w_sda};
              if (r_bit_cnt == 3'd0) begin
                r_bit_done <= 1'b1;
                if (!r_rx_rw) begin
                  r_rx_data  <= {r_shift[I2C_DATA_W-2:0], w_sda};
                  r_rx_valid <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
              end
            end else if (w_scl_fall && r_bit_done) begin
              // Reads still walk through the ACK slot, but the master owns SDA there.
              r_bit_done <= 1'b0;
              r_sda_oe   <= ~r_rx_rw;
              r_state    <= ACK_D;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe     = r_sda_oe;
  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.rx_rw      = r_rx_rw;
  assign bus.addr_match = r_addr_match;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed self-checking bench for i2c_slave_rx; bit-bangs an I2C master with open-drain SDA.
module tb_i2c_slave_rx;

  localparam int Q = 5;  // clk cycles per quarter SCL period
`ifdef I2C_SLAVE_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  logic m_scl;
  logic m_sda;
  int   checks;
  int   failures;

  logic [7:0] got_q[$];
  int         oe_rises;
  int         valid_long;
  logic       prev_oe;
  logic       prev_valid;

  i2c_slave_rx_if bus_if ();

  assign bus_if.scl = m_scl;
  assign bus_if.sda = m_sda & ~bus_if.sda_oe;

  i2c_slave_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    prev_oe    = 1'b0;
    prev_valid = 1'b0;
    oe_rises   = 0;
    valid_long = 0;
  end

  always @(negedge clk) begin
    if (bus_if.rx_valid) got_q.push_back(bus_if.rx_data);
    if (bus_if.rx_valid && prev_valid) valid_long++;
    if (bus_if.sda_oe && !prev_oe) oe_rises++;
    prev_oe    = bus_if.sda_oe;
    prev_valid = bus_if.rx_valid;
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic clear_mon();
    got_q.delete();
    oe_rises   = 0;
    valid_long = 0;
  endtask

  task automatic send_start();
    m_sda = 1'b1;
    wait_q(1);
    m_scl = 1'b1;
    wait_q(1);
    m_sda = 1'b0;
    wait_q(1);
    m_scl = 1'b0;
    wait_q(1);
  endtask

  task automatic send_stop();
    m_sda = 1'b0;
    wait_q(1);
    m_scl = 1'b1;
    wait_q(1);
    m_sda = 1'b1;
    wait_q(2);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    wait_q(1);
    m_scl = 1'b1;
    wait_q(2);
    m_scl = 1'b0;
    wait_q(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw);
    for (int i = 6; i >= 0; i--) send_bit(a[i]);
    send_bit(rw);
  endtask

  // Master releases SDA for the ACK slot; samples target drive mid SCL-high.
  task automatic ack_slot(output logic oe, output logic line);
    m_sda = 1'b1;
    wait_q(1);
    m_scl = 1'b1;
    wait_q(1);
    oe   = bus_if.sda_oe;
    line = bus_if.sda;
    wait_q(1);
    m_scl = 1'b0;
    wait_q(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.sda_oe !== 1'b0 || bus_if.rx_valid !== 1'b0 || bus_if.rx_rw !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: oe=%b valid=%b rw=%b want 0/0/0",
               bus_if.sda_oe, bus_if.rx_valid, bus_if.rx_rw);
    end
    checks++;
    if (bus_if.rx_data !== 8'h00 || bus_if.addr_match !== 1'b0 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: data=%h match=%b busy=%b want 00/0/0",
               bus_if.rx_data, bus_if.addr_match, bus_if.busy);
    end
    wait_q(4);
    checks++;
    if (bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_bus: busy=%b want 0", bus_if.busy);
    end
  endtask

  task automatic test_basic_write();
    logic oe, ln;
    clear_mon();
    send_start();
    checks++;
    if (bus_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_start: busy=%b want 1", bus_if.busy);
    end
    send_addr(7'h27, 1'b0);
    ack_slot(oe, ln);
    checks++;
    if (oe !== 1'b1 || ln !== 1'b0) begin
      failures++;
      $display("FAIL basic_addr_ack: oe=%b sda=%b want 1/0", oe, ln);
    end
    checks++;
    if (bus_if.addr_match !== 1'b1) begin
      failures++;
      $display("FAIL basic_match: addr_match=%b want 1", bus_if.addr_match);
    end
    send_byte(8'hA5);
    ack_slot(oe, ln);
    checks++;
    if (oe !== 1'b1 || ln !== 1'b0) begin
      failures++;
      $display("FAIL basic_data_ack: oe=%b sda=%b want 1/0", oe, ln);
    end
    checks++;
    if (got_q.size() !== 1) begin
      failures++;
      $display("FAIL basic_count: pulses=%0d want 1", got_q.size());
    end else if (got_q[0] !== 8'hA5) begin
      failures++;
      $display("FAIL basic_data: rx_data=%h want a5", got_q[0]);
    end
    checks++;
    if (bus_if.addr_match !== 1'b1 || valid_long !== 0) begin
      failures++;
      $display("FAIL basic_hold: addr_match=%b long_valid=%0d want 1/0",
               bus_if.addr_match, valid_long);
    end
    send_stop();
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.addr_match !== 1'b0 || bus_if.sda_oe !== 1'b0) begin
      failures++;
      $display("FAIL basic_stop: busy=%b match=%b oe=%b want 0/0/0",
               bus_if.busy, bus_if.addr_match, bus_if.sda_oe);
    end
  endtask

  task automatic test_mismatch();
    logic oe, ln;
    clear_mon();
    send_start();
    send_addr(7'h12, 1'b0);
    ack_slot(oe, ln);
    checks++;
    if (oe !== 1'b0 || ln !== 1'b1) begin
      failures++;
      $display("FAIL mis_addr_ack: oe=%b sda=%b want 0/1", oe, ln);
    end
    send_byte(8'h3C);
    ack_slot(oe, ln);
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.addr_match !== 1'b0) begin
      failures++;
      $display("FAIL mis_flags: busy=%b match=%b want 1/0", bus_if.busy, bus_if.addr_match);
    end
    send_stop();
    checks++;
    if (got_q.size() !== 0 || oe_rises !== 0 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL mis_quiet: pulses=%0d oe_rises=%0d busy=%b want 0/0/0",
               got_q.size(), oe_rises, bus_if.busy);
    end
  endtask

  task automatic test_multi_byte();
    logic oe, ln;
    logic [7:0] bytes [3];
    bytes[0] = 8'h01;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h80;
    clear_mon();
    send_start();
    send_addr(7'h27, 1'b0);
    ack_slot(oe, ln);
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i]);
      ack_slot(oe, ln);
      checks++;
      if (oe !== 1'b1) begin
        failures++;
        $display("FAIL multi_ack%0d: oe=%b want 1", i, oe);
      end
    end
    send_stop();
    checks++;
    if (got_q.size() !== 3) begin
      failures++;
      $display("FAIL multi_count: pulses=%0d want 3", got_q.size());
    end else if (got_q[0] !== 8'h01 || got_q[1] !== 8'hFF || got_q[2] !== 8'h80) begin
      failures++;
      $display("FAIL multi_order: got %h %h %h want 01 ff 80", got_q[0], got_q[1], got_q[2]);
    end
    checks++;
    if (oe_rises !== 4 || valid_long !== 0) begin
      failures++;
      $display("FAIL multi_oe: oe_rises=%0d long_valid=%0d want 4/0", oe_rises, valid_long);
    end
  endtask

  task automatic test_partial_byte();
    logic oe, ln;
    clear_mon();
    send_start();
    send_addr(7'h27, 1'b0);
    ack_slot(oe, ln);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    send_stop();
    checks++;
    if (got_q.size() !== 0 || bus_if.sda_oe !== 1'b0 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL partial_drop: pulses=%0d oe=%b busy=%b want 0/0/0",
               got_q.size(), bus_if.sda_oe, bus_if.busy);
    end
    clear_mon();
    send_start();
    send_addr(7'h27, 1'b0);
    ack_slot(oe, ln);
    send_byte(8'h55);
    ack_slot(oe, ln);
    send_stop();
    checks++;
    if (got_q.size() !== 1) begin
      failures++;
      $display("FAIL partial_next_count: pulses=%0d want 1", got_q.size());
    end else if (got_q[0] !== 8'h55) begin
      failures++;
      $display("FAIL partial_next_data: rx_data=%h want 55", got_q[0]);
    end
  endtask

  task automatic test_repeated_start();
    logic oe, ln;
    clear_mon();
    send_start();
    send_addr(7'h27, 1'b0);
    ack_slot(oe, ln);
    checks++;
    if (bus_if.rx_rw !== 1'b0 || bus_if.addr_match !== 1'b1) begin
      failures++;
      $display("FAIL rs_first: rw=%b match=%b want 0/1", bus_if.rx_rw, bus_if.addr_match);
    end
    send_start();
    checks++;
    if (bus_if.addr_match !== 1'b0 || bus_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL rs_restart: match=%b busy=%b want 0/1", bus_if.addr_match, bus_if.busy);
    end
    send_addr(7'h27, 1'b1);
    checks++;
    if (bus_if.rx_rw !== 1'b1) begin
      failures++;
      $display("FAIL rs_rw: rx_rw=%b want 1", bus_if.rx_rw);
    end
    ack_slot(oe, ln);
    checks++;
    if (oe !== 1'b1 || bus_if.addr_match !== 1'b1) begin
      failures++;
      $display("FAIL rs_ack: oe=%b match=%b want 1/1", oe, bus_if.addr_match);
    end
    send_byte(8'hFF);
    ack_slot(oe, ln);
    checks++;
    if (oe !== 1'b0 || got_q.size() !== 0) begin
      failures++;
      $display("FAIL rs_read_byte: oe=%b pulses=%0d want 0/0", oe, got_q.size());
    end
    send_stop();
  endtask

  task automatic test_reset_mid_data();
    logic oe, ln;
    clear_mon();
    send_start();
    send_addr(7'h27, 1'b0);
    ack_slot(oe, ln);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.rx_data !== 8'h55) begin
      failures++;
      $display("FAIL mid_pre: busy=%b data=%h want 1/55", bus_if.busy, bus_if.rx_data);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.addr_match !== 1'b0 || bus_if.rx_data !== 8'h00 ||
        bus_if.sda_oe !== 1'b0 || bus_if.rx_valid !== 1'b0 || bus_if.rx_rw !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b match=%b data=%h oe=%b valid=%b rw=%b want 0/0/00/0/0/0",
               bus_if.busy, bus_if.addr_match, bus_if.rx_data, bus_if.sda_oe,
               bus_if.rx_valid, bus_if.rx_rw);
    end
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    ack_slot(oe, ln);
    checks++;
    if (oe !== 1'b0 || got_q.size() !== 0 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_ignore: oe=%b pulses=%0d busy=%b want 0/0/0",
               oe, got_q.size(), bus_if.busy);
    end
    send_stop();
    send_start();
    send_addr(7'h27, 1'b0);
    ack_slot(oe, ln);
    send_byte(8'h9A);
    ack_slot(oe, ln);
    send_stop();
    checks++;
    if (got_q.size() !== 1) begin
      failures++;
      $display("FAIL mid_recover_count: pulses=%0d want 1", got_q.size());
    end else if (got_q[0] !== 8'h9A) begin
      failures++;
      $display("FAIL mid_recover_data: rx_data=%h want 9a", got_q[0]);
    end
  endtask

  task automatic test_general_call();
    logic oe, ln;
    int   exp_n;
    clear_mon();
    exp_n = GC_EN ? 1 : 0;
    send_start();
    send_addr(7'h00, 1'b0);
    ack_slot(oe, ln);
    checks++;
    if (oe !== GC_EN || bus_if.addr_match !== GC_EN) begin
      failures++;
      $display("FAIL gc_ack: oe=%b match=%b want %b/%b", oe, bus_if.addr_match, GC_EN, GC_EN);
    end
    send_byte(8'h06);
    ack_slot(oe, ln);
    send_stop();
    checks++;
    if (got_q.size() !== exp_n) begin
      failures++;
      $display("FAIL gc_count: pulses=%0d want %0d", got_q.size(), exp_n);
    end else if (exp_n == 1 && got_q[0] !== 8'h06) begin
      failures++;
      $display("FAIL gc_data: rx_data=%h want 06", got_q[0]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_scl    = 1'b1;
    m_sda    = 1'b1;
    reset    = 1'b1;
    test_reset();
    test_basic_write();
    test_mismatch();
    test_multi_byte();
    test_partial_byte();
    test_repeated_start();
    test_reset_mid_data();
    test_general_call();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
